hex_scan_ctrl: RTL and testbench
================================

// Module: hex_scan_ctrl
// PURPOSE
//  Scheduler that shares one combinational BCD-to-7-segment decoder (active-low, gfedcba)
//  among NUM_DIGITS HEX displays. Holds a 4-bit value per digit, written through a
//  valid/ready port. Presents one value per time slot to the decoder and latches the
//  returned segments into that digit's output register. Sits between control logic and HEX pins.
// PARAMETERS
//  NUM_DIGITS  4   number of digits served; 2..8
//  SCAN_DIV    16  clock cycles per digit slot; >=3 (decoder settle budget = SCAN_DIV-2)
// PORTS
//  CLOCK_50   in   1              system clock, rising edge
//  RST_N      in   1              asynchronous, active-low reset
//  wr_valid   in   1              write request
//  wr_ready   out  1              write accepted when wr_valid & wr_ready
//  wr_digit   in   $clog2(NUM_DIGITS) target digit index
//  wr_value   in   4              BCD value; 10..15 = blank
//  dec_bcd    out  4              to shared decoder input (registered)
//  dec_seg    in   7              from shared decoder output (active-low)
//  HEX        out  7*NUM_DIGITS   digit i = HEX[7*i+6:7*i], registered, active-low
//  scan_idx   out  $clog2(NUM_DIGITS) digit currently owning the decoder
//  frame_done out  1              1-cycle pulse after the last digit is captured
// BEHAVIOUR
//  Reset (async, immediate): val[*]=4'hF, HEX=all 1s (blank), dec_bcd=4'h0, scan_idx=0,
//   state=S_LOAD, slot counter=0, wr_ready=1, frame_done=0.
//  FSM, one pass per slot:
//   S_LOAD    1 cycle: dec_bcd <= val[scan_idx]; -> S_SETTLE
//   S_SETTLE  SCAN_DIV-2 cycles (slot counter); -> S_CAPTURE
//   S_CAPTURE 1 cycle: HEX[scan_idx] <= (val[scan_idx]>9) ? 7'h7F : dec_seg;
//             scan_idx <= (scan_idx==NUM_DIGITS-1) ? 0 : scan_idx+1; -> S_LOAD
//  frame_done=1 in the cycle after the capture of digit NUM_DIGITS-1 (coincides with S_LOAD of digit 0).
//  Capture uses val[] as sampled at S_LOAD (latched copy), not the live register.
//  wr_ready = 0 only while in S_CAPTURE, else 1. Accepted write updates val[wr_digit]
//   on the same clock edge. wr_digit >= NUM_DIGITS: accepted, no effect.
//  Write to the digit in S_SETTLE: no effect on the current slot; shown next frame.
//  Write-to-display latency: <= (NUM_DIGITS+1)*SCAN_DIV cycles.
//  Decoder is combinational; dec_seg is sampled only in S_CAPTURE.
//  Reset mid-slot: aborts the slot; no partial HEX update.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: at capture, digit i (i>0) is blanked (7'h7F) when
//   val[i]==0 and every val[j], j>i, is 0 or >9. Digit 0 is never zero-blanked.
//  Undefined: zero digits display 7'b1000000 regardless of position.
// TESTING (NUM_DIGITS=4, SCAN_DIV=16)
//  1 Reset held, then released -> HEX=28'hFFFFFFF, wr_ready=1, scan_idx=0; frame_done
//    first pulses 64 cycles after release.
//  2 Write d0..d3 = 1,2,3,4; wait 2 frames -> HEX0=1111001, HEX1=0100100, HEX2=0110000,
//    HEX3=0011001; dec_bcd steps 1,2,3,4 once per 16 cycles.
//  3 Write d2=4'hB -> after one frame, HEX2=1111111; other digits unchanged.
//  4 Hold wr_valid with d1=9 across an S_CAPTURE cycle -> wr_ready=0 that cycle, write
//    accepted next cycle; HEX1=0011000 within 80 cycles.
//  5 Assert RST_N low mid S_SETTLE of digit 2 -> HEX all 1s, val reset, scan_idx=0
//    without waiting for a clock edge.
//  6 Macro defined, d3..d0 = 0,0,5,0 -> HEX3=HEX2=1111111, HEX1=0010010, HEX0=1000000;
//    macro undefined -> HEX3=HEX2=1000000.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexes one external BCD-to-7-segment decoder across NUM_DIGITS HEX displays.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros (digit 0 is never blanked).
module hex_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          RST_N,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
  input  logic [3:0]                    wr_value,
  output logic [3:0]                    dec_bcd,
  input  logic [6:0]                    dec_seg,
  output logic [7*NUM_DIGITS-1:0]       HEX,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SCAN_DIV - 3);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W:0]   DIGITS      = (IDX_W + 1)'(NUM_DIGITS);
  localparam logic [6:0]       SEG_BLANK   = 7'h7F;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] slot_cnt;
  logic [3:0]       val [NUM_DIGITS];
  logic             cur_blank;
  logic             lz_blank;
  logic             wr_fire;

  assign wr_fire = wr_valid && wr_ready && ({1'b0, wr_digit} < DIGITS);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) state <= S_LOAD;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    wr_ready   = 1'b1;
    case (state)
      S_LOAD:    next_state = S_SETTLE;
      S_SETTLE:  if (slot_cnt == SETTLE_LAST) next_state = S_CAPTURE;
      S_CAPTURE: begin
        next_state = S_LOAD;
        wr_ready   = 1'b0;
      end
      default:   next_state = S_LOAD;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N)                slot_cnt <= '0;
    else if (state == S_SETTLE) slot_cnt <= slot_cnt + CNT_W'(1);
    else                       slot_cnt <= '0;
  end

  // Leading-zero test is evaluated at load time so capture sees a consistent snapshot.
  always_comb begin
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (scan_idx != '0 && val[scan_idx] == 4'd0) begin
      lz_blank = 1'b1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (j > int'(scan_idx) && val[j] inside {[4'd1:4'd9]}) lz_blank = 1'b0;
      end
    end
`endif
  end

  // NOTE: the small digit store is reset explicitly because blank-at-reset is visible behaviour.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_DIGITS; i++) val[i] <= 4'hF;
      HEX        <= '1;
      dec_bcd    <= 4'h0;
      scan_idx   <= '0;
      cur_blank  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_fire) val[wr_digit] <= wr_value;
      case (state)
        S_LOAD: begin
          dec_bcd   <= val[scan_idx];
          cur_blank <= (val[scan_idx] > 4'd9) || lz_blank;
        end
        S_CAPTURE: begin
          HEX[7*scan_idx +: 7] <= cur_blank ? SEG_BLANK : dec_seg;
          if (scan_idx == LAST_IDX) begin
            scan_idx   <= '0;
            frame_done <= 1'b1;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=16): timeline model plus directed literal checks.
// Honours LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_hex_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_digit = 2'd0;
  logic [3:0]  wr_value = 4'd0;
  logic        wr_ready;
  logic [3:0]  dec_bcd;
  logic [6:0]  dec_seg;
  logic [27:0] hex;
  logic [1:0]  scan_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External decoder; codes above 9 give a visible non-blank pattern so DUT blanking is exercised.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h40;  4'd1: seg7 = 7'h79;  4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;  4'd4: seg7 = 7'h19;  4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;  4'd7: seg7 = 7'h78;  4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h18;  default: seg7 = 7'h06;
    endcase
  endfunction

  assign dec_seg = seg7(dec_bcd);

  hex_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .CLOCK_50  (clk),
    .RST_N     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_digit  (wr_digit),
    .wr_value  (wr_value),
    .dec_bcd   (dec_bcd),
    .dec_seg   (dec_seg),
    .HEX       (hex),
    .scan_idx  (scan_idx),
    .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: n counts rising edges since reset release; edge k runs slot phase (k-1)%SD of digit ((k-1)/SD)%ND.
  int         n = 0;
  logic [3:0] mval [ND] = '{default: 4'hF};
  logic [6:0] mhex [ND] = '{default: 7'h7F};
  logic [3:0] snap_bcd = 4'h0;
  logic       snap_blank = 1'b0;

  function automatic logic blank_rule(input int d);
    logic b;
    b = mval[d] > 4'd9;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && mval[d] == 4'd0) begin
      logic higher_empty;
      higher_empty = 1'b1;
      for (int j = d + 1; j < ND; j++)
        if (mval[j] >= 4'd1 && mval[j] <= 4'd9) higher_empty = 1'b0;
      b = b || higher_empty;
    end
`endif
    return b;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      n = 0;
      for (int i = 0; i < ND; i++) begin
        mval[i] = 4'hF;
        mhex[i] = 7'h7F;
      end
      snap_bcd   = 4'h0;
      snap_blank = 1'b0;
    end else begin
      int  p, d;
      logic acc;
      acc = wr_valid && (n % SD != SD - 1);
      n++;
      p = (n - 1) % SD;
      d = ((n - 1) / SD) % ND;
      if (p == 0) begin
        snap_bcd   = mval[d];
        snap_blank = blank_rule(d);
      end
      if (p == SD - 1) mhex[d] = snap_blank ? 7'h7F : seg7(snap_bcd);
      if (acc) mval[wr_digit] = wr_value;
    end
  end

  initial forever begin
    @(negedge clk);
    check("hex",        {4'h0, mhex[3], mhex[2], mhex[1], mhex[0]}, {4'h0, hex});
    check("dec_bcd",    dec_bcd,    snap_bcd);
    check("scan_idx",   scan_idx,   (n / SD) % ND);
    check("wr_ready",   wr_ready,   (n % SD) != SD - 1);
    check("frame_done", frame_done, n > 0 && (n % (SD * ND)) == 0);
  end

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < SD * ND + 8; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    timeout("frame_done_wait");
  endtask

  task automatic write(input logic [1:0] d, input logic [3:0] v);
    logic rdy;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_digit = d;
    wr_value = v;
    for (int t = 0; t < SD + 2; t++) begin
      rdy = wr_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
      if (t == SD + 1) timeout("write_accept");
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic found;

    // Reset state and first frame timing
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_hex",      {4'h0, hex}, 32'h0FFFFFFF);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_scan_idx", scan_idx, 0);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (frame_done) begin
        cyc = i;
        break;
      end
    end
    check("first_frame_done", cyc, 64);

    // Digits 1,2,3,4
    write(2'd0, 4'd1);
    write(2'd1, 4'd2);
    write(2'd2, 4'd3);
    write(2'd3, 4'd4);
    wait_frame();
    wait_frame();
    check("hex0_1", hex[6:0],   7'h79);
    check("hex1_2", hex[13:7],  7'h24);
    check("hex2_3", hex[20:14], 7'h30);
    check("hex3_4", hex[27:21], 7'h19);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check("dec_bcd_step", dec_bcd, k + 1);
      repeat (SD) @(negedge clk);
    end

    // Value above 9 blanks its digit only
    write(2'd2, 4'hB);
    wait_frame();
    wait_frame();
    check("b_hex0", hex[6:0],   7'h79);
    check("b_hex1", hex[13:7],  7'h24);
    check("b_hex2", hex[20:14], 7'h7F);
    check("b_hex3", hex[27:21], 7'h19);

    // Write held across a capture cycle
    for (int i = 0; i <= SD; i++) begin
      @(negedge clk);
      if (n % SD == SD - 1) break;
    end
    wr_valid = 1'b1;
    wr_digit = 2'd1;
    wr_value = 4'd9;
    check("ready_in_capture", wr_ready, 0);
    @(negedge clk);
    check("ready_after_capture", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (hex[13:7] == 7'h18) begin
        found = 1'b1;
        break;
      end
    end
    check("hex1_9_latency", found, 1);

    // Asynchronous reset in the middle of digit 2's settle window
    for (int i = 0; i < SD * ND + 1; i++) begin
      @(negedge clk);
      if (n % (SD * ND) == 40) break;
    end
    check("in_digit2_slot", scan_idx, 2);
    #3 rst_n = 1'b0;
    #1;
    check("async_hex",        {4'h0, hex}, 32'h0FFFFFFF);
    check("async_scan_idx",   scan_idx, 0);
    check("async_dec_bcd",    dec_bcd, 0);
    check("async_wr_ready",   wr_ready, 1);
    check("async_frame_done", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frame();
    check("val_reset_blank", {4'h0, hex}, 32'h0FFFFFFF);

    // Zero digits, with and without leading-zero blanking
    write(2'd3, 4'd0);
    write(2'd2, 4'd0);
    write(2'd1, 4'd5);
    write(2'd0, 4'd0);
    wait_frame();
    wait_frame();
`ifdef LEADING_ZERO_BLANK_EN
    check("z_hex3", hex[27:21], 7'h7F);
    check("z_hex2", hex[20:14], 7'h7F);
`else
    check("z_hex3", hex[27:21], 7'h40);
    check("z_hex2", hex[20:14], 7'h40);
`endif
    check("z_hex1", hex[13:7], 7'h12);
    check("z_hex0", hex[6:0],  7'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
